// File: rtl/mem_req_master.sv
// Single-outstanding CPU load/store master for a 48-bit big-endian, byte-addressed
// memory port; extracts and extends 8/16/32/48-bit read data into a right-justified result.
module mem_req_master #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 48,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req_valid,
   output logic                  cpu_req_ready,
   input  logic                  cpu_req_write,
   input  logic [1:0]            cpu_req_size,
   input  logic                  cpu_req_signed,
   input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
   input  logic [DATA_WIDTH-1:0] cpu_req_data,
   output logic                  cpu_rsp_valid,
   output logic [DATA_WIDTH-1:0] cpu_rsp_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_req_write,
   output logic [1:0]            mem_req_data_size,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_data_in
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   // Store data keeps only the LSBs covered by the access size.
   function automatic logic [DATA_WIDTH-1:0] mask_store(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0]            sz);
      logic [DATA_WIDTH-1:0] m;
      case (sz)
         2'd0:    m = {{(DATA_WIDTH-8){1'b0}},  d[7:0]};
         2'd1:    m = {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
         2'd2:    m = {{(DATA_WIDTH-32){1'b0}}, d[31:0]};
         default: m = d;
      endcase
      return m;
   endfunction

   // The first byte of the access sits in the bus MSBs; right-justify and extend it.
   function automatic logic [DATA_WIDTH-1:0] extract_load(input logic [DATA_WIDTH-1:0] din,
                                                          input logic [1:0]            sz,
                                                          input logic                  sgn);
      logic                  ext;
      logic [DATA_WIDTH-1:0] r;
      ext = sgn & din[DATA_WIDTH-1];
      case (sz)
         2'd0:    r = {{(DATA_WIDTH-8){ext}},  din[DATA_WIDTH-1 -: 8]};
         2'd1:    r = {{(DATA_WIDTH-16){ext}}, din[DATA_WIDTH-1 -: 16]};
         2'd2:    r = {{(DATA_WIDTH-32){ext}}, din[DATA_WIDTH-1 -: 32]};
         default: r = din;
      endcase
      return r;
   endfunction

   state_t                state_q;
   logic [2:0]            wait_cnt_q;
   logic                  write_q;
   logic                  signed_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  mem_wr_q;
   logic [1:0]            size_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic [DATA_WIDTH-1:0] store_data_d;
   logic [DATA_WIDTH-1:0] load_data_d;

   assign store_data_d = mask_store(cpu_req_data, cpu_req_size);
   assign load_data_d  = extract_load(mem_data_in, size_q, signed_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         write_q     <= 1'b0;
         signed_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         addr_q      <= '0;
         mem_wr_q    <= 1'b0;
         size_q      <= '0;
         wdata_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cpu_req_valid) begin
                  addr_q   <= cpu_req_addr;
                  size_q   <= cpu_req_size;
                  write_q  <= cpu_req_write;
                  signed_q <= cpu_req_signed;
                  wdata_q  <= store_data_d;
                  mem_wr_q <= cpu_req_write;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               mem_wr_q <= 1'b0;
               if (write_q) begin
                  rsp_data_q  <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  wait_cnt_q <= 3'(READ_LATENCY - 1);
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               // Address stays on the bus until the registered read data is captured.
               if (wait_cnt_q != '0) begin
                  wait_cnt_q <= wait_cnt_q - 3'd1;
               end else begin
                  rsp_data_q  <= load_data_d;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_req_ready     = (state_q == IDLE);
   assign cpu_rsp_valid     = rsp_valid_q;
   assign cpu_rsp_data      = rsp_data_q;
   assign mem_addr          = addr_q;
   assign mem_req_write     = mem_wr_q;
   assign mem_req_data_size = size_q;
   assign mem_data          = wdata_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: two instances (read latency 1 and 3) share a byte-array responder;
// results are checked against hand-written vectors and a byte-level shadow memory model.
module tb_mem_req_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic        rst, v1, v3, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [47:0] req_data;

   logic        rdy1, rv1, mw1, rdy3, rv3, mw3;
   logic [47:0] rd1, md1, din1, rd3, md3, din3;
   logic [31:0] ma1, ma3;
   logic [1:0]  ms1, ms3;

   mem_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(48), .READ_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .cpu_req_valid(v1), .cpu_req_ready(rdy1),
      .cpu_req_write(req_write), .cpu_req_size(req_size), .cpu_req_signed(req_signed),
      .cpu_req_addr(req_addr), .cpu_req_data(req_data), .cpu_rsp_valid(rv1),
      .cpu_rsp_data(rd1), .mem_addr(ma1), .mem_req_write(mw1), .mem_req_data_size(ms1),
      .mem_data(md1), .mem_data_in(din1));

   mem_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(48), .READ_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .cpu_req_valid(v3), .cpu_req_ready(rdy3),
      .cpu_req_write(req_write), .cpu_req_size(req_size), .cpu_req_signed(req_signed),
      .cpu_req_addr(req_addr), .cpu_req_data(req_data), .cpu_rsp_valid(rv3),
      .cpu_rsp_data(rd3), .mem_addr(ma3), .mem_req_write(mw3), .mem_req_data_size(ms3),
      .mem_data(md3), .mem_data_in(din3));

   function automatic int nbytes(input logic [1:0] sz);
      case (sz)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 6;
      endcase
   endfunction

   // Responder: 256-byte RAM indexed by the low address byte, read data delayed per instance.
   logic [7:0]  ram [0:255];
   logic [47:0] pipe1;
   logic [47:0] pipe3 [0:2];

   function automatic logic [47:0] rd48(input logic [31:0] a);
      logic [47:0] v;
      v = '0;
      for (int i = 0; i < 6; i++) v = {v[39:0], ram[8'(a + 32'(i))]};
      return v;
   endfunction

   always @(posedge clk) begin : responder
      int nbw;
      pipe1    <= rd48(ma1);
      pipe3[0] <= rd48(ma3);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
      nbw = nbytes(ms1);
      if (mw1)
         for (int i = 0; i < 6; i++)
            if (i < nbw) ram[8'(ma1 + 32'(i))] <= md1[8*(nbw-1-i) +: 8];
   end

   assign din1 = pipe1;
   assign din3 = pipe3[2];

   // Reference model: shadow of the RAM contents, loads evaluated as integers.
   logic [7:0] shadow [0:255];

   function automatic logic [47:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                              input bit sg);
      int     nb;
      longint v;
      nb = nbytes(sz);
      v  = 0;
      for (int i = 0; i < nb; i++) v = v * 256 + longint'(shadow[8'(a + 32'(i))]);
      if (sg && nb < 6 && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
      return 48'(v);
   endfunction

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   task automatic chk_reset(input string nm, input bit use3);
      check({nm, " ready"},     64'(use3 ? rdy3 : rdy1), 64'd1);
      check({nm, " rsp_valid"}, 64'(use3 ? rv3 : rv1),   64'd0);
      check({nm, " rsp_data"},  64'(use3 ? rd3 : rd1),   64'd0);
      check({nm, " mem_addr"},  64'(use3 ? ma3 : ma1),   64'd0);
      check({nm, " mem_wr"},    64'(use3 ? mw3 : mw1),   64'd0);
      check({nm, " mem_size"},  64'(use3 ? ms3 : ms1),   64'd0);
      check({nm, " mem_data"},  64'(use3 ? md3 : md1),   64'd0);
   endtask

   // One request on an idle instance; called and returning just after a falling edge.
   task automatic txn(input bit use3, input bit wr, input logic [1:0] sz, input bit sg,
                      input logic [31:0] a, input logic [47:0] d, input logic [47:0] exp,
                      input string nm);
      int          lat, wr_cnt, exp_lat, nb;
      logic [47:0] exp_wd;
      lat     = 0;
      wr_cnt  = 0;
      nb      = nbytes(sz);
      exp_lat = wr ? 2 : (use3 ? 5 : 3);
      exp_wd  = 48'(longint'(d) % (longint'(1) << (8*nb)));
      if (wr)
         for (int i = 0; i < nb; i++)
            shadow[8'(a + 32'(i))] = 8'(longint'(d) >> (8*(nb-1-i)));
      check({nm, " idle ready"}, 64'(use3 ? rdy3 : rdy1), 64'd1);
      req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_data = d;
      if (use3) v3 = 1'b1; else v1 = 1'b1;
      @(negedge clk);
      v1 = 1'b0;
      v3 = 1'b0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         check({nm, " busy ready"}, 64'(use3 ? rdy3 : rdy1), 64'd0);
         if (use3 ? mw3 : mw1) begin
            wr_cnt++;
            check({nm, " wdata"}, 64'(use3 ? md3 : md1), 64'(exp_wd));
         end
         if (use3 ? rv3 : rv1) begin
            lat = c;
            check({nm, " rsp data"}, 64'(use3 ? rd3 : rd1), 64'(exp));
         end else begin
            check({nm, " addr"}, 64'(use3 ? ma3 : ma1), 64'(a));
            check({nm, " size"}, 64'(use3 ? ms3 : ms1), 64'(sz));
         end
         @(negedge clk);
      end
      check({nm, " latency"},     64'(lat),    64'(exp_lat));
      check({nm, " write count"}, 64'(wr_cnt), wr ? 64'd1 : 64'd0);
      check({nm, " pulse end"},   64'(use3 ? rv3 : rv1),   64'd0);
      check({nm, " data hold"},   64'(use3 ? rd3 : rd1),   64'(exp));
      check({nm, " ready again"}, 64'(use3 ? rdy3 : rdy1), 64'd1);
   endtask

   typedef struct {
      bit          wr;
      logic [1:0]  sz;
      bit          sg;
      logic [31:0] addr;
      logic [47:0] data;
      logic [47:0] exp;
   } vec_t;

   vec_t vecs [12];
   vec_t bb   [3];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          acc, nrsp;
      int          acc_t [3];
      int          rsp_t [3];
      bit          pend, wr;
      logic [1:0]  sz;
      bit          sg;
      logic [31:0] a;
      logic [47:0] d;

      vecs[0]  = '{1'b1, 2'd3, 1'b0, 32'h10,       48'hDEADBEEF1234, 48'h0};
      vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,       48'h0,            48'h0000DEADBEEF};
      vecs[2]  = '{1'b0, 2'd3, 1'b0, 32'h10,       48'h0,            48'hDEADBEEF1234};
      vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h20,       48'hAAAABBBB80F0, 48'h0};
      vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h20,       48'h0,            48'hFFFFFFFFFF80};
      vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h20,       48'h0,            48'h000000000080};
      vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h20,       48'h0,            48'hFFFFFFFF80F0};
      vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h20,       48'h0,            48'h0000000080F0};
      vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'hFFFF,     48'hAAAABBBBCCCC, 48'h0};
      vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'hFFFF,     48'h0,            48'h00000000CCCC};
      vecs[10] = '{1'b0, 2'd2, 1'b1, 32'h11,       48'h0,            48'hFFFFADBEEF12};
      vecs[11] = '{1'b0, 2'd3, 1'b1, 32'h10,       48'h0,            48'hDEADBEEF1234};

      bb[0] = '{1'b0, 2'd3, 1'b0, 32'h10, 48'h0, 48'hDEADBEEF1234};
      bb[1] = '{1'b0, 2'd1, 1'b1, 32'h20, 48'h0, 48'hFFFFFFFF80F0};
      bb[2] = '{1'b0, 2'd2, 1'b1, 32'h11, 48'h0, 48'hFFFFADBEEF12};

      rst = 1'b1; v1 = 1'b0; v3 = 1'b0;
      req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_data = '0;
      repeat (2) @(negedge clk);
      chk_reset("reset lat1", 1'b0);
      chk_reset("reset lat3", 1'b1);
      rst = 1'b0;

      for (int k = 0; k < 12; k++)
         txn(1'b0, vecs[k].wr, vecs[k].sz, vecs[k].sg, vecs[k].addr, vecs[k].data,
             vecs[k].exp, $sformatf("vec%0d", k));

      txn(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 48'h0, 48'hDEADBEEF1234, "lat3 load48");

      // Valid held high across three loads.
      acc = 0; nrsp = 0; pend = 1'b0;
      for (int k = 0; k < 3; k++) begin acc_t[k] = -100; rsp_t[k] = -100; end
      req_write = bb[0].wr; req_size = bb[0].sz; req_signed = bb[0].sg;
      req_addr = bb[0].addr; req_data = bb[0].data; v1 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (rv1) begin
            if (nrsp < 3) begin
               rsp_t[nrsp] = c;
               check($sformatf("b2b rsp%0d data", nrsp), 64'(rd1), 64'(bb[nrsp].exp));
            end
            nrsp++;
         end
         if (pend) begin
            pend = 1'b0;
            if (acc < 3) begin
               req_write = bb[acc].wr; req_size = bb[acc].sz; req_signed = bb[acc].sg;
               req_addr = bb[acc].addr; req_data = bb[acc].data;
            end else begin
               v1 = 1'b0;
            end
         end
         if (rdy1 && v1) begin
            if (acc < 3) acc_t[acc] = c;
            acc++;
            pend = 1'b1;
         end
         @(negedge clk);
      end
      check("b2b accepts",    64'(acc),  64'd3);
      check("b2b responses",  64'(nrsp), 64'd3);
      check("b2b accept gap1", 64'(acc_t[1] - acc_t[0]), 64'd4);
      check("b2b accept gap2", 64'(acc_t[2] - acc_t[1]), 64'd4);
      check("b2b first rsp",   64'(rsp_t[0] - acc_t[0]), 64'd3);
      check("b2b rsp gap1",    64'(rsp_t[1] - rsp_t[0]), 64'd4);
      check("b2b rsp gap2",    64'(rsp_t[2] - rsp_t[1]), 64'd4);

      // Reset while waiting for read data.
      req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h10; req_data = 48'h123456789ABC; v1 = 1'b1;
      @(negedge clk);
      v1 = 1'b0;
      @(negedge clk);
      check("rst wait busy", 64'(rdy1), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset("rst in wait", 1'b0);
      for (int c = 0; c < 6; c++) begin
         check("rst no rsp", 64'(rv1), 64'd0);
         @(negedge clk);
      end
      txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 48'h0, 48'h0000DEADBEEF, "post rst load");

      // Fill the whole RAM with 48-bit stores, then random traffic against the model.
      for (int k = 0; k < 43; k++) begin
         d = {16'($urandom), 32'($urandom)};
         txn(1'b0, 1'b1, 2'd3, 1'b0, 32'(6*k), d, 48'h0, $sformatf("fill%0d", k));
      end
      for (int k = 0; k < 60; k++) begin
         wr = ($urandom_range(0, 9) < 3);
         sz = 2'($urandom_range(0, 3));
         sg = 1'($urandom_range(0, 1));
         a  = $urandom;
         d  = {16'($urandom), 32'($urandom)};
         txn(1'b0, wr, sz, sg, a, d, wr ? 48'h0 : model_load(a, sz, sg), $sformatf("rnd%0d", k));
      end
      for (int k = 0; k < 10; k++) begin
         sz = 2'($urandom_range(0, 3));
         sg = 1'($urandom_range(0, 1));
         a  = $urandom;
         txn(1'b1, 1'b0, sz, sg, a, 48'h0, model_load(a, sz, sg), $sformatf("rnd3_%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_req_master.md
# mem_req_master

Initiator-side bus master for the CPU data memory interface: it accepts one load/store request at a time from the CPU core and drives the byte-addressed memory port that the test RAM responds on. The block sequences the request (issue, wait for registered read data, respond) and extracts, sign- or zero-extends, and right-justifies 8/16/32/48-bit read data from the 48-bit big-endian bus. It sits between the CPU load/store path and the memory model or RAM.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 48, memory data bus width (fixed at 48; other values are not supported)
- READ_LATENCY, 1, memory cycles from sampled address to valid read data (range 1..7)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- cpu_req_valid  in  1  request present
- cpu_req_ready  out  1  block can accept a request
- cpu_req_write  in  1  1 = store, 0 = load
- cpu_req_size  in  2  0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = 48-bit (ReqDataSz8..48)
- cpu_req_signed  in  1  sign-extend load result (ignored for stores and for size 3)
- cpu_req_addr  in  ADDR_WIDTH  byte address
- cpu_req_data  in  48  store data, right-justified
- cpu_rsp_valid  out  1  one-cycle completion pulse
- cpu_rsp_data  out  48  load result, right-justified and extended; 0 for stores
- mem_addr  out  ADDR_WIDTH  address to memory
- mem_req_write  out  1  write strobe
- mem_req_data_size  out  2  size code, same encoding as cpu_req_size
- mem_data  out  48  write data, right-justified, bits above size forced to 0
- mem_data_in  in  48  read data {mem[a], mem[a+1], ..., mem[a+5]}

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: cpu_req_ready=1. If cpu_req_valid is 1 at a clock edge, the block latches addr, size, write, signed, and data, then moves to ISSUE. All other CPU inputs are ignored.
- ISSUE, one cycle: mem_addr, mem_req_data_size, and mem_data are driven from the latched request. mem_req_write = latched write.
  - Store: next state is RESP.
  - Load: next state is WAIT, with the wait counter loaded to READ_LATENCY-1.
- WAIT: mem_addr and mem_req_data_size are held, and mem_req_write=0.
  - Counter nonzero: decrement.
  - Counter zero: capture the extracted mem_data_in into cpu_rsp_data, then go to RESP.
- RESP: cpu_rsp_valid=1 for exactly one cycle, then IDLE.
- Read extraction from mem_data_in: size 0 uses [47:40], size 1 uses [47:32], size 2 uses [47:16], size 3 uses [47:0]. The result is right-justified, then zero-extended, or sign-extended from the value MSB if signed=1.
- Store: mem_data = cpu_req_data masked to 8/16/32/48 LSBs. cpu_rsp_data = 0.
- Address arithmetic is not performed. mem_addr = latched addr unchanged; wrap-around is the responder's job. There are no alignment checks, so misaligned access is legal.
- mem_req_write is 1 only in ISSUE of a store, never for more than one cycle per request.

## Timing
- Reset: on rst=1 at an edge, state goes to IDLE regardless of current state, and all outputs are forced to reset values.
  - Reset values: cpu_req_ready=1 (asserted from the first cycle after reset), cpu_rsp_valid=0, cpu_rsp_data=0, mem_addr=0, mem_req_write=0, mem_req_data_size=0, mem_data=0.
  - A request in flight is abandoned and no rsp pulse is produced.
- All outputs are registered, with no combinational path from input to output. cpu_req_ready is a decode of registered state.
- Cycle numbering, with the accept edge ending cycle 0:
  - ISSUE is cycle 1.
  - Load: WAIT is cycles 2..1+READ_LATENCY, and cpu_rsp_valid is high in cycle 2+READ_LATENCY.
  - Store: cpu_rsp_valid is high in cycle 2.
- Next accept is possible in the cycle after RESP. Back-to-back load throughput is one per 4 cycles at READ_LATENCY=1.
- cpu_rsp_data holds its value after the pulse until the next capture or reset.
- If cpu_req_valid is held through RESP, it is accepted at the first IDLE edge.

## Test plan
- Load 32-bit, unsigned: responder returns mem_data_in=48'hDEADBEEF1234 at addr 0x10, READ_LATENCY=1 -> cpu_rsp_valid pulses in cycle 3 with cpu_rsp_data=48'h0000DEADBEEF, and mem_req_write stays 0 throughout.
- Load 8-bit and 16-bit, signed versus unsigned: data [47:32]=16'h80F0 -> size 0 signed gives 48'hFFFFFFFFFF80, size 0 unsigned gives 48'h80, size 1 signed gives 48'hFFFFFFFF80F0.
- Store 16-bit, cpu_req_data=48'hAAAA_BBBB_CCCC, addr 0xFFFF -> exactly one cycle with mem_req_write=1, mem_data=48'hCCCC, mem_addr=0xFFFF, size=1; rsp pulse in cycle 2 with cpu_rsp_data=0.
- READ_LATENCY=3: 48-bit load -> mem_addr stable for cycles 1..4, and cpu_rsp_valid is high in cycle 5 only.
- Back-to-back: cpu_req_valid held high for 3 loads -> cpu_req_ready is low while busy, each request is accepted exactly once, and rsp pulses are 4 cycles apart.
- Reset in WAIT: rst=1 for one cycle during WAIT -> no rsp pulse, all outputs at reset values, and cpu_req_ready=1 in the next cycle; a new load then completes normally.
